// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and pixel-format helpers shared by the scan
// controller and its counters.
package vga_pkg;

  localparam int unsigned CNT_W = 11;

  localparam logic [CNT_W-1:0] H_VISIBLE = 11'd640;
  localparam logic [CNT_W-1:0] H_FRONT   = 11'd16;
  localparam logic [CNT_W-1:0] H_SYNC    = 11'd96;
  localparam logic [CNT_W-1:0] H_BACK    = 11'd48;
  localparam logic [CNT_W-1:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam logic [CNT_W-1:0] V_VISIBLE = 11'd480;
  localparam logic [CNT_W-1:0] V_FRONT   = 11'd10;
  localparam logic [CNT_W-1:0] V_SYNC    = 11'd2;
  localparam logic [CNT_W-1:0] V_BACK    = 11'd33;
  localparam logic [CNT_W-1:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are [START, END) in counter units.
  localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Replicate MSBs so full-scale input maps to full-scale DAC code.
  function automatic logic [3:0] exp3to4(input logic [2:0] v);
    return {v, v[2]};
  endfunction

  function automatic logic [3:0] exp2to4(input logic [1:0] v);
    return {v, v};
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Mod-N scan counter: advances on en_i, wraps N-1 -> 0 and flags the wrap.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter logic [CNT_W-1:0] N = H_TOTAL
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == N - 1'b1);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan generator: pixel-rate divider, h/v counters, and a one-pixel
// output stage that aligns drawer colour with blanking and sync.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [7:0]       RGB_in,
  output logic [CNT_W-1:0] pixelX,
  output logic [CNT_W-1:0] pixelY,
  output logic             pixEn,
  output logic             startOfFrame,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             hSync,
  output logic             vSync,
  output logic             blankN
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             visible, hs_raw, vs_raw;
  logic             vis_q, hs_q, vs_q;
  logic             sof_q;
  logic             blank_q, hsync_q, vsync_q;
  logic [3:0]       red_q, green_q, blue_q;
  rgb332_t          pix;

  assign div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  assign pixEn = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) div_q <= '0;
    else         div_q <= div_d;
  end

  vga_sync_counter #(.N(H_TOTAL)) u_hcnt (
    .clk(clk), .resetN(resetN), .en_i(pixEn),
    .cnt_o(h_cnt), .wrap_o(h_wrap)
  );

  vga_sync_counter #(.N(V_TOTAL)) u_vcnt (
    .clk(clk), .resetN(resetN), .en_i(h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap)
  );

  assign pixelX = h_cnt;
  assign pixelY = v_cnt;

  always_comb begin
    visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    hs_raw  = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    vs_raw  = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
  end

  // Flags trail the counters by one clk so that, at the pixEn edge, they
  // describe the same pixel whose colour the drawer is presenting.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vis_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      sof_q <= 1'b0;
    end else begin
      vis_q <= visible;
      hs_q  <= hs_raw;
      vs_q  <= vs_raw;
      sof_q <= v_wrap;
    end
  end

  assign pix = rgb332_t'(RGB_in);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blank_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pixEn) begin
      blank_q <= vis_q;
      hsync_q <= hs_q;
      vsync_q <= vs_q;
      red_q   <= vis_q ? exp3to4(pix.r) : 4'h0;
      green_q <= vis_q ? exp3to4(pix.g) : 4'h0;
      blue_q  <= vis_q ? exp2to4(pix.b) : 4'h0;
    end
  end

  assign startOfFrame = sof_q;
  assign blankN       = blank_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;

endmodule
